// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and helpers for the branch resolution controller.
//   RedirectStateType : redirect FSM encoding (IDLE / PEND / DRAIN)
//   BranchUpdateSt    : one predictor update record {pc, target, taken}
//   rob_older()       : ROB age comparison with MSB wrap bit
`ifndef PROC_VALEN
`define PROC_VALEN 32
`endif

package BranchCtrlPkg;

  localparam int unsigned PKG_VALEN = `PROC_VALEN;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    DRAIN
  } RedirectStateType;

  typedef struct packed {
    logic [PKG_VALEN-1:0] pc;
    logic [PKG_VALEN-1:0] target;
    logic                 taken;
  } BranchUpdateSt;

  // True when index a is older than index b. Both are zero-extended to 32 bits;
  // w is the real index width, its top bit being the wrap bit.
  function automatic logic rob_older(input logic [31:0] a, input logic [31:0] b,
                                     input int unsigned w);
    logic [31:0] msb_mask;
    logic [31:0] low_mask;
    logic        a_msb;
    logic        b_msb;
    msb_mask = 32'd1 << (w - 1);
    low_mask = msb_mask - 32'd1;
    a_msb    = |(a & msb_mask);
    b_msb    = |(b & msb_mask);
    if (a_msb != b_msb) return (a & low_mask) > (b & low_mask);
    return (a & low_mask) < (b & low_mask);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Bundle of all non-clock signals of branch_resolve_ctrl.
//   bru_*      : per-unit resolution inputs and the shared ready
//   redirect_* : front-end redirect channel (valid/ready)
//   flush_done_i, global_flush_i : back-end flush events
//   upd_*      : predictor update channel (valid/ready)
// Modport slave is the controller; master is its environment.
`ifndef PROC_VALEN
`define PROC_VALEN 32
`endif

interface branch_resolve_ctrl_if #(
  parameter int unsigned BRU_NUM   = 2,
  parameter int unsigned ROB_IDX_W = 6,
  parameter int unsigned VALEN     = `PROC_VALEN
);

  logic [BRU_NUM-1:0]                bru_valid_i;
  logic [BRU_NUM-1:0][ROB_IDX_W-1:0] bru_rob_idx_i;
  logic [BRU_NUM-1:0][VALEN-1:0]     bru_pc_i;
  logic [BRU_NUM-1:0][VALEN-1:0]     bru_target_i;
  logic [BRU_NUM-1:0]                bru_taken_i;
  logic [BRU_NUM-1:0]                bru_redirect_i;
  logic                              bru_ready_o;

  logic                              redirect_valid_o;
  logic [VALEN-1:0]                  redirect_pc_o;
  logic [ROB_IDX_W-1:0]              redirect_rob_idx_o;
  logic                              redirect_ready_i;

  logic                              flush_done_i;
  logic                              global_flush_i;

  logic                              upd_valid_o;
  logic [VALEN-1:0]                  upd_pc_o;
  logic [VALEN-1:0]                  upd_target_o;
  logic                              upd_taken_o;
  logic                              upd_ready_i;

  modport slave (
    input  bru_valid_i, bru_rob_idx_i, bru_pc_i, bru_target_i, bru_taken_i, bru_redirect_i,
    output bru_ready_o,
    output redirect_valid_o, redirect_pc_o, redirect_rob_idx_o,
    input  redirect_ready_i, flush_done_i, global_flush_i,
    output upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o,
    input  upd_ready_i
  );

  modport master (
    output bru_valid_i, bru_rob_idx_i, bru_pc_i, bru_target_i, bru_taken_i, bru_redirect_i,
    input  bru_ready_o,
    input  redirect_valid_o, redirect_pc_o, redirect_rob_idx_o,
    output redirect_ready_i, flush_done_i, global_flush_i,
    input  upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o,
    output upd_ready_i
  );

endinterface

// File: rtl/branch_update_fifo.sv
// Multi-write, single-read FIFO of predictor update records.
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : per-slot write strobes; set slots are stored lowest slot first
//   wr_data   : per-slot records
//   wr_ready  : at least WR_NUM free entries (from the registered count)
//   rd_valid  : head entry present
//   rd_data   : head entry, zero when empty
//   rd_ready  : consumer takes the head entry
module branch_update_fifo
  import BranchCtrlPkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WR_NUM = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WR_NUM-1:0] wr_en,
  input  BranchUpdateSt wr_data [WR_NUM],
  output logic          wr_ready,
  output logic          rd_valid,
  output BranchUpdateSt rd_data,
  input  logic          rd_ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  BranchUpdateSt  mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [AW:0]    count;
  logic [AW+1:0]  free_cnt;
  logic [AW:0]    n_wr;
  logic [AW-1:0]  waddr [WR_NUM];

  // Pointers carry one extra wrap bit, so their difference is the fill level.
  assign count    = wr_ptr - rd_ptr;
  assign free_cnt = (AW + 2)'(DEPTH) - {1'b0, count};
  assign wr_ready = free_cnt >= (AW + 2)'(WR_NUM);
  assign rd_valid = count != '0;
  assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // Set strobes are packed into consecutive addresses in slot order.
  always_comb begin
    logic [AW:0] slot_ptr;
    n_wr     = '0;
    slot_ptr = '0;
    for (int unsigned i = 0; i < WR_NUM; i++) begin
      slot_ptr = wr_ptr + n_wr;
      waddr[i] = slot_ptr[AW-1:0];
      if (wr_en[i]) n_wr = n_wr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WR_NUM; i++) begin
      if (wr_en[i]) mem[waddr[i]] <= wr_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_wr;
      if (rd_valid && rd_ready) rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Back-end branch resolution controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_resolve_ctrl_if.slave carrying the BRU inputs, the
//              front-end redirect channel, flush events and the predictor
//              update channel.
// Picks the oldest surviving mispredict each cycle, holds it as a redirect
// until accepted, then uses its ROB index as a kill boundary until the flush
// completes. Every surviving resolution is queued as a predictor update.
`ifndef PROC_VALEN
`define PROC_VALEN 32
`endif

module branch_resolve_ctrl
  import BranchCtrlPkg::*;
#(
  parameter int unsigned BRU_NUM   = 2,
  parameter int unsigned ROB_IDX_W = 6,
  parameter int unsigned VALEN     = `PROC_VALEN,
  parameter int unsigned UPD_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_ctrl_if.slave bus
);

  RedirectStateType     state;
  RedirectStateType     state_d;
  logic [VALEN-1:0]     held_pc;
  logic [ROB_IDX_W-1:0] held_rob;
  logic                 load;

  logic [BRU_NUM-1:0]   live;
  logic [BRU_NUM-1:0]   survive;
  logic [BRU_NUM-1:0]   enq;
  logic                 has_mp;
  logic [ROB_IDX_W-1:0] win_rob;
  logic [VALEN-1:0]     win_tgt;

  BranchUpdateSt        wr_data [BRU_NUM];
  BranchUpdateSt        rd_data;

  // Resolution filtering: drop anything younger than the held boundary, then
  // anything younger than this cycle's oldest mispredict.
  always_comb begin
    live    = '0;
    survive = '0;
    has_mp  = 1'b0;
    win_rob = '0;
    win_tgt = '0;
    for (int unsigned i = 0; i < BRU_NUM; i++) begin
      live[i] = bus.bru_valid_i[i] &&
                !((state != IDLE) &&
                  rob_older(32'(held_rob), 32'(bus.bru_rob_idx_i[i]), ROB_IDX_W));
    end
    for (int unsigned i = 0; i < BRU_NUM; i++) begin
      if (live[i] && bus.bru_redirect_i[i] &&
          (!has_mp || rob_older(32'(bus.bru_rob_idx_i[i]), 32'(win_rob), ROB_IDX_W))) begin
        has_mp  = 1'b1;
        win_rob = bus.bru_rob_idx_i[i];
        win_tgt = bus.bru_target_i[i];
      end
    end
    for (int unsigned i = 0; i < BRU_NUM; i++) begin
      survive[i] = live[i] &&
                   !(has_mp && rob_older(32'(win_rob), 32'(bus.bru_rob_idx_i[i]), ROB_IDX_W));
    end
    if (bus.global_flush_i) begin
      survive = '0;
      has_mp  = 1'b0;
    end
  end

  assign enq = survive & {BRU_NUM{bus.bru_ready_o}};

  // Any surviving mispredict is older than the held boundary, so it always
  // takes over, even over a same-cycle accept or flush completion.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    if (bus.global_flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (has_mp) begin
            state_d = PEND;
            load    = 1'b1;
          end
        end
        PEND: begin
          if (has_mp) begin
            load = 1'b1;
          end else if (bus.redirect_ready_i) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (has_mp) begin
            state_d = PEND;
            load    = 1'b1;
          end else if (bus.flush_done_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      held_pc  <= '0;
      held_rob <= '0;
    end else begin
      state <= state_d;
      if (load) begin
        held_pc  <= win_tgt;
        held_rob <= win_rob;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!((|bus.bru_valid_i) && !bus.bru_ready_o));
    end
  end

  assign bus.redirect_valid_o   = state == PEND;
  assign bus.redirect_pc_o      = held_pc;
  assign bus.redirect_rob_idx_o = held_rob;

  always_comb begin
    for (int unsigned i = 0; i < BRU_NUM; i++) begin
      wr_data[i].pc     = bus.bru_pc_i[i];
      wr_data[i].target = bus.bru_target_i[i];
      wr_data[i].taken  = bus.bru_taken_i[i];
    end
  end

  branch_update_fifo #(
    .DEPTH  (UPD_DEPTH),
    .WR_NUM (BRU_NUM)
  ) u_upd_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (enq),
    .wr_data  (wr_data),
    .wr_ready (bus.bru_ready_o),
    .rd_valid (bus.upd_valid_o),
    .rd_data  (rd_data),
    .rd_ready (bus.upd_ready_i)
  );

  assign bus.upd_pc_o     = rd_data.pc;
  assign bus.upd_target_o = rd_data.target;
  assign bus.upd_taken_o  = rd_data.taken;

endmodule
